alu_mdu: RTL and testbench

- Parametrised successor to the single-cycle datapath ALU.
- Keeps a combinational ALU path with a wider op set: add/sub/logic/shift/compare/lui.
- Adds an iterative multiply/divide unit (MDU) with architectural HI/LO registers and a start/busy/done handshake.
- Sits in the EX stage. Hazard logic stalls on busy.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/mdu_iter.sv | 164 ++++++++++++++++
 rtl/alu_mdu.sv | 81 ++++++++
 tb/tb_alu_mdu.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU and the iterative multiply/divide unit.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_SRL  = 4'b0100,
    ALU_SRA  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_XOR  = 4'b0111,
    ALU_NOR  = 4'b1000,
    ALU_SLT  = 4'b1001,
    ALU_SLTU = 4'b1010,
    ALU_LUI  = 4'b1011
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } md_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers: shift-add multiply,
// restoring divide on operand magnitudes, sign fix-up applied on the final step.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic             mthi_i,
  input  logic             mtlo_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;    // product high half / partial remainder
  logic [WIDTH-1:0] sh_q, sh_d;      // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] dvs_q, dvs_d;    // multiplicand / divisor magnitude
  logic [WIDTH-1:0] dvd_q, dvd_d;    // raw dividend, returned as HI on divide by zero
  md_op_e           op_q, op_d;
  logic             negp_q, negp_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             in_signed, a_neg, b_neg, is_div;
  logic [WIDTH-1:0] a_mag, b_mag, acc_step, sh_step, hi_fix, lo_fix;
  logic [WIDTH:0]   mul_sum, rem_sh, diff;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign in_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
  assign a_neg     = in_signed & a_i[WIDTH-1];
  assign b_neg     = in_signed & b_i[WIDTH-1];
  assign a_mag     = a_neg ? -a_i : a_i;
  assign b_mag     = b_neg ? -b_i : b_i;
  assign is_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);

  // One radix-2 step of either algorithm.
  always_comb begin
    mul_sum = {1'b0, acc_q} + {1'b0, (sh_q[0] ? dvs_q : {WIDTH{1'b0}})};
    rem_sh  = {acc_q, sh_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    if (is_div) begin
      if (diff[WIDTH]) begin
        acc_step = rem_sh[WIDTH-1:0];
        sh_step  = {sh_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_step = diff[WIDTH-1:0];
        sh_step  = {sh_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_step = mul_sum[WIDTH:1];
      sh_step  = {mul_sum[0], sh_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up on the final step's result.
  always_comb begin
    prod     = {acc_step, sh_step};
    prod_fix = negp_q ? -prod : prod;
    if (is_div) begin
      if (dvs_q == '0) begin
        lo_fix = '1;
        hi_fix = dvd_q;
      end else begin
        lo_fix = negp_q ? -sh_step : sh_step;
        hi_fix = negr_q ? -acc_step : acc_step;
      end
    end else begin
      hi_fix = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix = prod_fix[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    op_d    = op_q;
    negp_d  = negp_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start_i) begin
          state_d = RUN;
          cnt_d   = '0;
          acc_d   = '0;
          sh_d    = a_mag;
          dvs_d   = b_mag;
          dvd_d   = a_i;
          op_d    = md_op_e'(op_i);
          negp_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
        end else begin
          if (mthi_i) hi_d = a_i;
          if (mtlo_i) lo_d = a_i;
        end
      end
      RUN: begin
        acc_d = acc_step;
        sh_d  = sh_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LastCnt) begin
          state_d = DONE;
          cnt_d   = '0;
          hi_d    = hi_fix;
          lo_d    = lo_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      op_q    <= MD_MULT;
      negp_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      op_q    <= op_d;
      negp_q  <= negp_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o = (state_q == RUN);
  assign done_o = (state_q == DONE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/alu_mdu.sv
// EX-stage combinational ALU plus iterative MDU with HI/LO.
// Define ALU_OVERFLOW_EN to add the signed add/sub overflow output ovf.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic [WIDTH-1:0] C,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef ALU_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;
  assign shamt = B[SHW-1:0];

  always_comb begin
    C = '0;
    case (ALUOp)
      ALU_ADD:  C = A + B;
      ALU_SUB:  C = A - B;
      ALU_AND:  C = A & B;
      ALU_OR:   C = A | B;
      ALU_SRL:  C = A >> shamt;
      ALU_SRA:  C = $signed(A) >>> shamt;
      ALU_SLL:  C = A << shamt;
      ALU_XOR:  C = A ^ B;
      ALU_NOR:  C = ~(A | B);
      ALU_SLT:  C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: C = {{(WIDTH-1){1'b0}}, (A < B)};
      ALU_LUI:  C = B << (WIDTH / 2);
      default:  C = '0;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  // Overflow: operands (B inverted for sub) agree in sign but the result does not.
  always_comb begin
    ovf = 1'b0;
    if (ALUOp == ALU_ADD) begin
      ovf = (A[WIDTH-1] == B[WIDTH-1]) && (C[WIDTH-1] != A[WIDTH-1]);
    end else if (ALUOp == ALU_SUB) begin
      ovf = (A[WIDTH-1] != B[WIDTH-1]) && (C[WIDTH-1] != A[WIDTH-1]);
    end
  end
`endif

  mdu_iter #(
    .WIDTH(WIDTH)
  ) u_mdu (
    .clk_i   (clk),
    .rst_i   (reset),
    .a_i     (A),
    .b_i     (B),
    .start_i (md_start),
    .op_i    (md_op),
    .mthi_i  (mthi),
    .mtlo_i  (mtlo),
    .busy_o  (busy),
    .done_o  (md_done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu at WIDTH=32.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B, C, hi, lo;
  logic [3:0]  ALUOp;
  logic        md_start, mthi, mtlo, busy, md_done;
  logic [1:0]  md_op;
`ifdef ALU_OVERFLOW_EN
  logic        ovf;
`endif

  int checks = 0;
  int errors = 0;
  int ncyc;

  alu_mdu #(
    .WIDTH(32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .ALUOp    (ALUOp),
    .C        (C),
    .md_start (md_start),
    .md_op    (md_op),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .busy     (busy),
    .md_done  (md_done),
    .hi       (hi),
    .lo       (lo)
`ifdef ALU_OVERFLOW_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the next rising edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    A        = a;
    B        = b;
    md_op    = op;
    md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
  endtask

  // Counts busy samples (one per negedge) until busy drops, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input string tag);
    ALUOp = op;
    A     = a;
    B     = b;
    #1;
    chk(tag, C, exp);
  endtask

  initial begin
    reset    = 1'b1;
    A        = '0;
    B        = '0;
    ALUOp    = '0;
    md_start = 1'b0;
    md_op    = 2'b00;
    mthi     = 1'b0;
    mtlo     = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", md_done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(negedge clk);
    reset = 1'b0;

    // ALU path
    alu(4'b0101, 32'h8000_0000, 32'd4, 32'hF800_0000, "sra");
    alu(4'b0100, 32'h8000_0000, 32'd4, 32'h0800_0000, "srl");
    alu(4'b1001, 32'h8000_0000, 32'd1, 32'd1, "slt");
    alu(4'b1010, 32'h8000_0000, 32'd1, 32'd0, "sltu");
    alu(4'b1011, 32'h8000_0000, 32'h1234, 32'h1234_0000, "lui");
    alu(4'b0000, 32'hFFFF_FFFF, 32'd2, 32'd1, "add_wrap");
    alu(4'b0001, 32'd0, 32'd1, 32'hFFFF_FFFF, "sub_wrap");
    alu(4'b1000, 32'h0F0F_0000, 32'h0000_00F0, 32'hF0F0_FF0F, "nor");
    alu(4'b0110, 32'd1, 32'h21, 32'd2, "sll_mask");
    alu(4'b0111, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, "xor");
    alu(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, "op1100");
    @(negedge clk);

    // mult -3*7
    start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(ncyc);
    chk("mult_busy_cycles", ncyc, 32);
    chk("mult_done", md_done, 1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);
    @(negedge clk);
    chk("mult_done_pulse", md_done, 0);

    start_op(2'b01, 32'hFFFF_FFFD, 32'd7);
    wait_done(ncyc);
    chk("multu_hi", hi, 32'd6);
    chk("multu_lo", lo, 32'hFFFF_FFEB);

    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(ncyc);
    chk("div_cycles", ncyc, 32);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    start_op(2'b11, 32'd7, 32'd0);
    wait_done(ncyc);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'd7);

    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(ncyc);
    chk("divmin_lo", lo, 32'h8000_0000);
    chk("divmin_hi", hi, 32'd0);

    // Disturbance mid-run: restart, mthi and operand changes are all ignored
    start_op(2'b11, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    A        = 32'hDEAD_BEEF;
    B        = 32'd3;
    md_op    = 2'b00;
    md_start = 1'b1;
    mthi     = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    mthi     = 1'b0;
    chk("dist_busy", busy, 1);
    wait_done(ncyc);
    chk("dist_cycles", ncyc, 26);
    chk("dist_lo", lo, 32'd14);
    chk("dist_hi", hi, 32'd2);

    // Start issued in the DONE cycle
    chk("done_before_restart", md_done, 1);
    start_op(2'b01, 32'd5, 32'd6);
    chk("restart_busy", busy, 1);
    wait_done(ncyc);
    chk("restart_cycles", ncyc, 32);
    chk("restart_lo", lo, 32'd30);
    chk("restart_hi", hi, 32'd0);

    // mthi/mtlo while not busy
    A    = 32'h0000_ABCD;
    mthi = 1'b1;
    mtlo = 1'b1;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("mthi_both_hi", hi, 32'h0000_ABCD);
    chk("mtlo_both_lo", lo, 32'h0000_ABCD);
    A    = 32'h0000_1111;
    mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mtlo_lo", lo, 32'h0000_1111);
    chk("mtlo_hi_kept", hi, 32'h0000_ABCD);

    // Asynchronous reset mid-divide
    start_op(2'b10, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", md_done, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_op(2'b11, 32'd100, 32'd7);
    wait_done(ncyc);
    chk("post_rst_cycles", ncyc, 32);
    chk("post_rst_lo", lo, 32'd14);
    chk("post_rst_hi", hi, 32'd2);

`ifdef ALU_OVERFLOW_EN
    ALUOp = 4'b0000;
    A     = 32'h7FFF_FFFF;
    B     = 32'd1;
    #1;
    chk("ovf_add", ovf, 1);
    chk("ovf_add_c", C, 32'h8000_0000);
    ALUOp = 4'b0001;
    A     = 32'd0;
    B     = 32'd1;
    #1;
    chk("ovf_sub", ovf, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
